// File: rtl/minv_mdiv_host.sv
// Host sequencer for the modular inverse/division engine:
// loads operands, starts the engine, streams the result back.
module minv_mdiv_host #(
  parameter int WORDS   = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  input  logic          cmd_op,
  output logic          cmd_ready,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          err,
  output logic [DW-1:0] datain,
  output logic          loadp,
  output logic          loada,
  output logic          loadb,
  output logic          minv_mdiv,
  output logic          minv_mdiv_en,
  output logic          outx1,
  output logic          outx2,
  input  logic [DW-1:0] regx1out,
  input  logic [DW-1:0] regx2out,
  input  logic          minv_mdiv_rdy,
  input  logic          minv_mdiv_flag
);

  localparam int CW = $clog2(WORDS) + 1;
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(WORDS - 1);
  localparam logic [TW-1:0] WD_LAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, LOADP, LOADA, LOADB,
    START, BLANK, WAIT, READ
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] wd_q, wd_d;
  logic          op_q, op_d;
  logic          err_q, err_d;
  logic          sel_q, sel_d;
  logic          armed_q, armed_d;
  logic          live_q;
  logic          last;

  assign last      = (cnt_q == CNT_LAST);
  assign minv_mdiv = op_q;
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wd_q    <= '0;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= 1'b0;
      armed_q <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      op_q    <= op_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      armed_q <= armed_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wd_d         = wd_q;
    op_d         = op_q;
    err_d        = err_q;
    sel_d        = sel_q;
    armed_d      = armed_q;
    cmd_ready    = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    out_data     = '0;
    datain       = '0;
    loadp        = 1'b0;
    loada        = 1'b0;
    loadb        = 1'b0;
    minv_mdiv_en = 1'b0;
    outx1        = 1'b0;
    outx2        = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = live_q;
        if (cmd_valid && live_q) begin
          op_d    = cmd_op;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = LOADP;
        end
      end
      LOADP, LOADA, LOADB: begin
        in_ready = 1'b1;
        if (in_valid) begin
          datain = in_data;
          loadp  = (state_q == LOADP);
          loada  = (state_q == LOADA);
          loadb  = (state_q == LOADB);
          cnt_d  = last ? '0 : cnt_q + 1'b1;
          if (last) begin
            if (state_q == LOADP)
              state_d = LOADA;
            else if (state_q == LOADA && !op_q)
              state_d = LOADB;
            else
              state_d = START;
          end
        end
      end
      START: begin
        minv_mdiv_en = 1'b1;
        armed_d      = 1'b0;
        state_d      = BLANK;
      end
      BLANK: begin
        // ready must be seen low once before a fresh rise counts
        if (!minv_mdiv_rdy) armed_d = 1'b1;
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (minv_mdiv_rdy && armed_q) begin
          sel_d   = minv_mdiv_flag;
          cnt_d   = '0;
          state_d = READ;
        end else begin
          if (!minv_mdiv_rdy) armed_d = 1'b1;
          if (TIMEOUT != 0 && wd_q == WD_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      READ: begin
        out_valid = 1'b1;
        out_last  = last;
        out_data  = sel_q ? regx2out : regx1out;
        if (out_ready) begin
          outx2 = sel_q;
          outx1 = !sel_q;
          cnt_d = last ? '0 : cnt_q + 1'b1;
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/minv_mdiv_host.md
Name: minv_mdiv_host

Overview:
- Host-side sequencer that drives the modular inverse/division engine through its 32-bit load/strobe port. It plays the initiator to the engine's responder.
- Accepts a command plus a word stream from a valid/ready upstream, then:
  - loads p, then a, then b (division only) into the engine;
  - pulses the start enable and waits for ready;
  - streams the 256-bit result back from whichever register the engine's flag selects.
- Sits between the system bus adapter and the engine top level.

Parameters:
- WORDS, 8, 32-bit beats per 256-bit operand/result
- DW, 32, word width
- TIMEOUT, 65535, max cycles waiting for engine ready before abort; 0 disables the watchdog

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_op  in  1  1=modular inverse, 0=modular division
- cmd_ready  out  1  host idle, command accepted on cmd_valid&cmd_ready
- in_valid  in  1  operand word valid
- in_data  in  DW  operand word, least-significant word first; order p, a, b
- in_ready  out  1  operand word accepted on in_valid&in_ready
- out_valid  out  1  result word valid
- out_data  out  DW  result word, least-significant first
- out_last  out  1  marks final result word
- out_ready  in  1  downstream accepts result word
- err  out  1  sticky timeout flag; cleared when the next command is accepted
- datain  out  DW  word to engine
- loadp  out  1  shift datain into engine p/v registers
- loada  out  1  shift datain into engine u register
- loadb  out  1  shift datain into engine x1 register
- minv_mdiv  out  1  operation select to engine, registered copy of cmd_op
- minv_mdiv_en  out  1  one-cycle start pulse
- outx1  out  1  shift engine x1 right by DW
- outx2  out  1  shift engine x2 right by DW
- regx1out  in  DW  engine x1 low word
- regx2out  in  DW  engine x2 low word
- minv_mdiv_rdy  in  1  engine done, level
- minv_mdiv_flag  in  1  0=result in x1, 1=result in x2

Behaviour:
- Reset (rst=0, async) forces:
  - state IDLE and all counters to 0;
  - all strobes, minv_mdiv_en, out_valid, out_last, err and in_ready to 0;
  - datain=0, minv_mdiv=0, cmd_ready=0.
- The first clock after reset release enters IDLE with cmd_ready=1.
- States: IDLE, LOADP, LOADA, LOADB, START, BLANK, WAIT, READ.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch cmd_op into minv_mdiv, clear err, clear the word counter, go to LOADP.
- LOADP, LOADA, LOADB:
  - in_ready=1.
  - On each in_valid&in_ready, in the same cycle: datain=in_data and the matching load strobe=1.
  - datain and strobes are combinational from in_data/in_valid, so there are zero cycles from in_data to datain.
  - No strobe is asserted in cycles without a handshake.
  - After WORDS beats: LOADP→LOADA; LOADA→LOADB if minv_mdiv=0, else START.
  - LOADB→START after WORDS beats.
  - In inverse mode, loadb is never asserted.
- START: minv_mdiv_en=1 for exactly one cycle, then BLANK.
- BLANK: one cycle, minv_mdiv_rdy ignored (stale ready from the previous op is masked). Then WAIT.
- WAIT:
  - The watchdog counts cycles in WAIT.
  - When minv_mdiv_rdy=1, latch minv_mdiv_flag into an internal sel, clear the word counter, go to READ.
  - If TIMEOUT≠0 and the count reaches TIMEOUT with rdy still 0: set err, go to IDLE, issue no reads.
  - rdy and timeout in the same cycle: rdy wins.
- READ:
  - out_valid=1.
  - out_data = regx2out if sel=1, else regx1out (combinational).
  - out_last=1 on beat WORDS-1.
  - On out_valid&out_ready: pulse outx2 (sel=1) or outx1 (sel=0) for that cycle and increment the counter.
  - After the beat with out_last: go to IDLE.
  - out_ready=0 holds out_data stable and asserts no shift.
- Never assert more than one of loadp/loada/loadb/outx1/outx2 in a cycle.
- in_ready=0 and out_valid=0 outside their respective states.
- cmd_valid outside IDLE is ignored (not queued).
- Word counter: log2(WORDS)+1 bits, compared to WORDS-1 for the transition; no wrap within an operand.
- Reset mid-operation aborts immediately and drives all outputs to reset values. The engine contents are then undefined; the next command reloads all operands.

Test Plan:
- Inverse, p words 0..7 = 0xFFFFFFFF…0xFFFFFFFD pattern, a = 1 → exactly 8 loadp then 8 loada pulses with datain equal to in_data, zero loadb, one en pulse; the model engine returns rdy with flag=0 and x1=1 → out words 1,0,0,0,0,0,0,0, out_last on the 8th, 8 outx1 pulses, zero outx2.
- Division: 24 input beats → 8 loadp, 8 loada, 8 loadb in order; flag=1 → reads come from regx2out with 8 outx2 pulses.
- Backpressure: toggle in_valid and out_ready randomly (50%) → strobe count is exactly 8 per operand and outx pulses equal accepted beats; out_data is stable while out_ready=0.
- Stale rdy: rdy held 1 from the previous op through START/BLANK → the host stays in WAIT until rdy falls and rises again; no early read.
- TIMEOUT=20, rdy never asserted → err=1 exactly 20 cycles into WAIT, cmd_ready=1 the next cycle, no outx pulses; the next command clears err.
- Assert rst low during LOADA beat 3 → all outputs 0 asynchronously; after release a full inverse command completes correctly.
